// File: rtl/window_buffer_7x7_ctrl.sv
// window_buffer_7x7_ctrl
// Control for the 7x7 window-buffer datapath. It accepts one 7-pixel column per beat from the
// line buffer and gates the datapath column counter. It tracks the column and row of every formed
// window, and it raises valid_o two cycles after the column that completes a window. The datapath
// shift registers have no enable, so a row must arrive without gaps. A gap discards the row and
// upstream resends it.
//
// Handshake: a column transfers in any cycle where in_valid_i and in_ready_o are both high
// (count_en_o). in_ready_o depends only on state, never on in_valid_i. Once a row has started,
// in_valid_i must stay high until the last column of that row. A low cycle aborts the row with err_o.

module window_buffer_7x7_ctrl #(
    parameter int COLS = 9,
    parameter int ROWS = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output logic       count_en_o,
    output logic       valid_o,
    output logic [9:0] win_col_o,
    output logic [9:0] win_row_o,
    output logic       last_o,
    output logic       err_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [2:0] state_dbg_o
);

    // Column index of the last column in a row, and row index of the last window row.
    localparam logic [9:0] LAST_COL      = 10'(COLS - 1);
    localparam logic [9:0] LAST_ROW      = 10'(ROWS - 7);
    // The first complete window appears when column index 6 is accepted.
    localparam logic [9:0] FIRST_WIN_COL = 10'd6;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_ROW = 3'd1,
        S_ROW      = 3'd2,
        S_DRAIN    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] col_cnt_q, col_cnt_d;
    logic [9:0] row_cnt_q, row_cnt_d;
    logic       drain_q, drain_d;

    // Two-stage window pipeline matching the datapath column-to-window latency.
    logic       p1_valid_q, p1_valid_d;
    logic [9:0] p1_col_q, p1_col_d;
    logic [9:0] p1_row_q, p1_row_d;
    logic       p1_last_q, p1_last_d;
    logic       p2_valid_q, p2_valid_d;
    logic [9:0] p2_col_q, p2_col_d;
    logic [9:0] p2_row_q, p2_row_d;
    logic       p2_last_q, p2_last_d;

    logic       ready;
    logic       accept;
    logic       row_end;

    // A transfer happens only while a row is open or about to open.
    assign accept     = in_valid_i & ready;
    // The column being accepted is the final one of the row.
    assign row_end    = (state_q == S_ROW) && (col_cnt_q == LAST_COL);

    // Next-state, counter and control-output logic for the frame FSM.
    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        drain_d   = drain_q;
        ready     = 1'b0;
        err_o     = 1'b0;
        done_o    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_WAIT_ROW;
                    row_cnt_d = 10'd0;
                    col_cnt_d = 10'd0;
                end
            end
            S_WAIT_ROW: begin
                // Idle cycles between rows are allowed here.
                ready = 1'b1;
                if (in_valid_i) begin
                    col_cnt_d = 10'd1;
                    state_d   = S_ROW;
                end
            end
            S_ROW: begin
                ready = 1'b1;
                if (in_valid_i) begin
                    if (col_cnt_q == LAST_COL) begin
                        col_cnt_d = 10'd0;
                        if (row_cnt_q == LAST_ROW) begin
                            state_d = S_DRAIN;
                            drain_d = 1'b0;
                        end else begin
                            row_cnt_d = row_cnt_q + 10'd1;
                            state_d   = S_WAIT_ROW;
                        end
                    end else begin
                        col_cnt_d = col_cnt_q + 10'd1;
                    end
                end else begin
                    // A gap breaks the contiguous shift. The row is dropped and will be resent.
                    err_o     = 1'b1;
                    col_cnt_d = 10'd0;
                    state_d   = S_WAIT_ROW;
                end
            end
            S_DRAIN: begin
                // Two cycles let the final window leave the pipeline.
                if (drain_q) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Launch a window tag for each accepted column from index 6 onward, then advance the pipeline.
    always_comb begin
        p1_valid_d = 1'b0;
        p1_col_d   = 10'd0;
        p1_row_d   = 10'd0;
        p1_last_d  = 1'b0;
        if (accept && (col_cnt_q >= FIRST_WIN_COL)) begin
            p1_valid_d = 1'b1;
            p1_col_d   = col_cnt_q - FIRST_WIN_COL;
            p1_row_d   = row_cnt_q;
            p1_last_d  = row_end && (row_cnt_q == LAST_ROW);
        end
        p2_valid_d = p1_valid_q;
        p2_col_d   = p1_col_q;
        p2_row_d   = p1_row_q;
        p2_last_d  = p1_last_q;
    end

    // State, counters and pipeline registers. Reset overrides every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            col_cnt_q  <= 10'd0;
            row_cnt_q  <= 10'd0;
            drain_q    <= 1'b0;
            p1_valid_q <= 1'b0;
            p1_col_q   <= 10'd0;
            p1_row_q   <= 10'd0;
            p1_last_q  <= 1'b0;
            p2_valid_q <= 1'b0;
            p2_col_q   <= 10'd0;
            p2_row_q   <= 10'd0;
            p2_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_cnt_q  <= col_cnt_d;
            row_cnt_q  <= row_cnt_d;
            drain_q    <= drain_d;
            p1_valid_q <= p1_valid_d;
            p1_col_q   <= p1_col_d;
            p1_row_q   <= p1_row_d;
            p1_last_q  <= p1_last_d;
            p2_valid_q <= p2_valid_d;
            p2_col_q   <= p2_col_d;
            p2_row_q   <= p2_row_d;
            p2_last_q  <= p2_last_d;
        end
    end

    // Output mapping. Window tags come straight from the second pipeline stage.
    always_comb begin
        in_ready_o  = ready;
        count_en_o  = accept;
        valid_o     = p2_valid_q;
        win_col_o   = p2_col_q;
        win_row_o   = p2_row_q;
        last_o      = p2_valid_q & p2_last_q;
        busy_o      = (state_q != S_IDLE);
        state_dbg_o = state_q;
    end

endmodule
